// File: rtl/cvxif_sched_pkg.sv
// Shared types and constants for the CV-X-IF result scheduler: per-ID entry
// state, stored result payload and the ID-count derivation.
package cvxif_sched_pkg;

    localparam int X_ID_WIDTH_DEF = 2;
    localparam int X_RFW_DEF      = 32;

    typedef enum logic [1:0] {
        ENTRY_FREE      = 2'd0,
        ENTRY_ISSUED    = 2'd1,
        ENTRY_COMMITTED = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic                 we;
        logic [4:0]           rd;
        logic [X_RFW_DEF-1:0] data;
    } entry_t;

    function automatic int num_ids(input int id_width);
        return 1 << id_width;
    endfunction

    localparam int NUM_IDS_DEF = num_ids(X_ID_WIDTH_DEF);

endpackage

// File: rtl/cvxif_result_scheduler_if.sv
// Issue, commit and result channels between the core side (master) and the
// coprocessor-side result scheduler (slave).
interface cvxif_result_scheduler_if #(
    parameter int X_ID_WIDTH = 2,
    parameter int X_RFW      = 32
);

    logic                  issue_valid;
    logic                  issue_ready;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic                  issue_accept;
    logic                  issue_we;
    logic [4:0]            issue_rd;
    logic [X_RFW-1:0]      issue_data;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic                  result_we;
    logic [4:0]            result_rd;
    logic [X_RFW-1:0]      result_data;

    logic                  protocol_err;

    modport master (
        output issue_valid, issue_id, issue_accept, issue_we, issue_rd, issue_data,
        input  issue_ready,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_we, result_rd, result_data,
        output result_ready,
        input  protocol_err
    );

    modport slave (
        input  issue_valid, issue_id, issue_accept, issue_we, issue_rd, issue_data,
        output issue_ready,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_we, result_rd, result_data,
        input  result_ready,
        output protocol_err
    );

endinterface

// File: rtl/cvxif_id_fifo.sv
// ID-order FIFO; pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
module cvxif_id_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cvxif_result_scheduler.sv
// CV-X-IF result scheduler: tracks accepted instructions per ID and returns
// their results on the result channel in commit order.
module cvxif_result_scheduler
    import cvxif_sched_pkg::*;
#(
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEF,
    parameter int X_RFW      = X_RFW_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    cvxif_result_scheduler_if.slave xif
);

    localparam int NUM_IDS = num_ids(X_ID_WIDTH);

    entry_state_e          state_q [NUM_IDS];
    entry_state_e          state_d [NUM_IDS];
    entry_t                payload_q [NUM_IDS];
    logic                  protocol_err_q;
    logic                  protocol_err_d;

    logic                  issue_ready_int;
    logic                  issue_write;
    logic                  commit_legal;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [X_ID_WIDTH-1:0] head_id;
    entry_t                head_entry;

    assign issue_ready_int = (state_q[xif.issue_id] == ENTRY_FREE);
    assign issue_write     = xif.issue_valid && issue_ready_int && xif.issue_accept;
    // A commit is only legal against the registered state, so committing an ID
    // in the same cycle it is issued counts as a protocol error.
    assign commit_legal    = xif.commit_valid && (state_q[xif.commit_id] == ENTRY_ISSUED);
    assign fifo_push       = commit_legal && !xif.commit_kill && !fifo_full;
    assign fifo_pop        = !fifo_empty && xif.result_ready;

    cvxif_id_fifo #(
        .DEPTH_LOG2 (X_ID_WIDTH),
        .WIDTH      (X_ID_WIDTH)
    ) u_order_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (xif.commit_id),
        .pop       (fifo_pop),
        .head_data (head_id),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                state_q[i]   <= ENTRY_FREE;
                payload_q[i] <= '0;
            end
            protocol_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                state_q[i] <= state_d[i];
            end
            if (issue_write) begin
                payload_q[xif.issue_id] <= '{we: xif.issue_we, rd: xif.issue_rd, data: xif.issue_data};
            end
            protocol_err_q <= protocol_err_d;
        end
    end

    // Issue, commit and result pop always target distinct IDs (FREE, ISSUED and
    // COMMITTED respectively), so the three updates never collide.
    always_comb begin
        for (int i = 0; i < NUM_IDS; i++) begin
            state_d[i] = state_q[i];
        end
        protocol_err_d = xif.commit_valid && !commit_legal;
        if (issue_write) begin
            state_d[xif.issue_id] = ENTRY_ISSUED;
        end
        if (commit_legal) begin
            state_d[xif.commit_id] = xif.commit_kill ? ENTRY_FREE : ENTRY_COMMITTED;
        end
        if (fifo_pop) begin
            state_d[head_id] = ENTRY_FREE;
        end
    end

    always_comb begin
        head_entry       = payload_q[head_id];
        xif.issue_ready  = issue_ready_int;
        xif.result_valid = !fifo_empty;
        xif.result_id    = '0;
        xif.result_we    = 1'b0;
        xif.result_rd    = '0;
        xif.result_data  = {X_RFW{1'b0}};
        if (!fifo_empty) begin
            xif.result_id   = head_id;
            xif.result_we   = head_entry.we;
            xif.result_rd   = head_entry.rd;
            xif.result_data = head_entry.data;
        end
        xif.protocol_err = protocol_err_q;
    end

endmodule

// File: doc/cvxif_result_scheduler.md
# cvxif_result_scheduler

Tracks CORE-V-X-Interface instructions from issue through commit to result delivery, on behalf of the coprocessor side of the interface. Accepted issue transactions are held in a per-ID table, released or discarded by the commit channel, and their results are presented on the single result channel in commit order with a valid/ready handshake. It sits between the coprocessor's decode/execute logic and the X-interface result port.

## Interface
- X_ID_WIDTH, 2: instruction ID width; table holds NUM_IDS = 2**X_ID_WIDTH entries.
- X_RFW, 32: result data width.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  scheduler can take an issue for issue_id.
- issue_id  in  X_ID_WIDTH  instruction ID.
- issue_accept  in  1  execute unit accepted the instruction; 0 means not tracked.
- issue_we  in  1  result writes a register.
- issue_rd  in  5  destination register.
- issue_data  in  X_RFW  precomputed result value.
- commit_valid  in  1  commit transaction (no ready; always taken).
- commit_id  in  X_ID_WIDTH  committed/killed ID.
- commit_kill  in  1  1 = discard instruction.
- result_valid  out  1  result presented.
- result_ready  in  1  core takes result.
- result_id  out  X_ID_WIDTH, result_we  out  1, result_rd  out  5, result_data  out  X_RFW  result fields.
- protocol_err  out  1  one-cycle pulse on illegal commit.

## Operation
- Entry state per ID: FREE, ISSUED, COMMITTED. Reset: all FREE.
- issue_ready = (entry[issue_id] == FREE), combinational from registered state only.
- Issue handshake (issue_valid & issue_ready): if issue_accept, entry -> ISSUED, store we/rd/data; else no change.
- Commit: entry[commit_id] ISSUED: kill -> FREE; no kill -> COMMITTED and commit_id pushed to order FIFO. Entry not ISSUED (including same-cycle issue of that ID): ignored, protocol_err = 1 next cycle.
- Order FIFO depth NUM_IDS; cannot overflow (each ID in FIFO at most once).
- result_valid = FIFO non-empty; result fields taken from entry at FIFO head.
- Result handshake (result_valid & result_ready): pop FIFO, entry -> FREE.
- result fields stable while result_valid & !result_ready.

## Timing
- Reset values: issue_ready 1 (all FREE), result_valid 0, result_id/we/rd/data 0, protocol_err 0; reset asserted mid-operation clears all entries and FIFO asynchronously, result_valid drops immediately.
- Issue -> earliest commit: next cycle. Commit -> result_valid: 1 cycle (registered FIFO write).
- Result handshake and commit in same cycle: both applied; FIFO push and pop together, count unchanged.
- ID freed by result or kill in cycle N: issue_ready for that ID high in N+1, not N.
- Back-to-back results: one per cycle with result_ready held high.

## Structure
- Shared package cvxif_sched_pkg: entry_state_e enum, entry_t struct (we, rd, data), NUM_IDS constant derivation.
- Sub-module cvxif_id_fifo: parameterised ID-order FIFO (push/pop/empty/full, wrap-around pointers with extra bit).

## Test plan
- Issue ID 1 (data 0xCAFE, rd 5, we 1), commit no-kill next cycle -> result_valid one cycle later with id 1, rd 5, data 0xCAFE; ready high -> valid drops, issue_ready for ID 1 high next cycle.
- Issue IDs 0,1,2,3, commit 2,0,3,1 -> results delivered in order 2,0,3,1; issue_ready low for all IDs before commits.
- Issue ID 2, commit with kill -> no result, ID 2 FREE next cycle, no protocol_err.
- Commit ID 3 never issued -> protocol_err single pulse, no result, table unchanged.
- Hold result_ready low 5 cycles with two committed entries -> head fields stable; then ready high -> two results on consecutive cycles; same-cycle commit during pop keeps order.
- Assert reset_n low with 3 entries ISSUED/COMMITTED -> result_valid 0 immediately, all issue_ready high after release.
